// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with 50% duty for both even and odd ratios.
// The ratio can be reloaded at runtime; a new ratio only ever starts on a period boundary.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_ld,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pos_q, pos_d;
  logic             neg_q;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] ld_val;
  logic             boundary;
  logic             start;

  assign ld_val   = (div_val < DIV_MIN) ? DIV_MIN : div_val;
  assign boundary = (state_q == ST_RUN) && (cnt_q == (div_cur_q - ONE));
  // A period starts either from idle or back-to-back at a boundary; en is only looked at then.
  assign start    = en && ((state_q == ST_IDLE) || boundary);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    if (div_ld) begin
      pend_d     = ld_val;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (boundary) begin
          cnt_d = '0;
          if (!en) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A load in the start cycle itself is already folded into pend_d above.
    if (start && pend_vld_d) begin
      div_cur_d  = pend_d;
      pend_vld_d = 1'b0;
    end

    pos_d  = (state_d == ST_RUN) && (cnt_d < (div_cur_d >> 1));
    tick_d = (state_d == ST_RUN) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_cur_q  <= DIV_RST;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      pos_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      pos_q      <= pos_d;
      tick_q     <= tick_d;
    end
  end

  // Odd ratios stretch the high phase by half a clk period via this falling-edge copy.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q & div_cur_q[0];
    end
  end

  assign clk_out = pos_q | neg_q;
  assign tick    = tick_q;
  assign div_cur = div_cur_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios then random traffic against a reference model
// that describes each output period in half-clk units (high for the first N of 2N halves).
module tb_clk_div_prog;

  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_ld;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_cur;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_run;
  int m_pos;
  int m_n;
  bit m_pend_v;
  int m_pend_n;

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_val (div_val),
    .div_ld  (div_ld),
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_div(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    m_run    = 1'b0;
    m_pos    = 0;
    m_n      = DEFAULT_DIV;
    m_pend_v = 1'b0;
    m_pend_n = 0;
  endtask

  // One rising edge: a period ends after N cycles; a new one begins only if en is high then.
  task automatic model_edge();
    bit period_over;
    period_over = !m_run || (m_pos == m_n - 1);
    if (div_ld) begin
      m_pend_v = 1'b1;
      m_pend_n = clamp_div(int'(div_val));
    end
    if (period_over) begin
      if (en) begin
        if (m_pend_v) m_n = m_pend_n;
        m_pend_v = 1'b0;
        m_run    = 1'b1;
        m_pos    = 0;
      end else begin
        m_run = 1'b0;
        m_pos = 0;
      end
    end else begin
      m_pos++;
    end
  endtask

  function automatic logic exp_clk(input int half);
    return logic'(m_run && ((2 * m_pos + half) < m_n));
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_val("tick", tick, logic'(m_run && m_pos == 0));
    check_val("clk_out_hi_half", clk_out, exp_clk(0));
    check_val("div_cur", div_cur, m_n);
    div_ld = 1'b0;
    @(negedge clk);
    #1;
    check_val("clk_out_lo_half", clk_out, exp_clk(1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input int v);
    div_ld  = 1'b1;
    div_val = WIDTH'(v);
    cycle();
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 64 && !(m_run && m_pos == p); i++) cycle();
  endtask

  // Called between edges; the checks right after rst rises need no clock edge.
  task automatic pulse_reset();
    div_ld = 1'b0;
    rst    = 1'b1;
    #1;
    model_reset();
    check_val("rst_clk_out", clk_out, 1'b0);
    check_val("rst_tick", tick, 1'b0);
    check_val("rst_div_cur", div_cur, DEFAULT_DIV);
    @(posedge clk);
    #1;
    check_val("rst_hold_clk_out", clk_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    div_ld  = 1'b0;
    div_val = '0;
    model_reset();
    #2;
    check_val("por_clk_out", clk_out, 1'b0);
    check_val("por_tick", tick, 1'b0);
    check_val("por_div_cur", div_cur, DEFAULT_DIV);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // default ratio 4
    run(12);
    // reload to 5 mid-period
    wait_pos(1);
    load(5);
    run(12);
    // last write wins: 6 then 3
    wait_pos(0);
    load(6);
    load(3);
    run(9);
    // clamp 0 and 1 to 2
    load(0);
    load(1);
    run(8);
    // load in the boundary cycle itself
    wait_pos(m_n - 1);
    load(7);
    run(16);
    // stop at boundary with N=8, restart later
    load(8);
    wait_pos(0);
    wait_pos(1);
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(10);
    // short en glitch mid-period is ignored
    wait_pos(2);
    en = 1'b0;
    cycle();
    en = 1'b1;
    run(10);
    // reset with pending 10 at cnt 5
    wait_pos(4);
    load(10);
    pulse_reset();
    run(12);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      en     = ($urandom_range(0, 9) != 0);
      div_ld = ($urandom_range(0, 7) == 0);
      div_val = WIDTH'($urandom_range(0, 12));
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset();
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
